mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the RV32I core's memory stage. It accepts one load or store per instruction from the execute side and drives a split read/write valid/ready memory bus. It holds the pipeline via STALL until the access completes, then returns aligned and extended load data to the memory-read pipeline register. It also flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYC, 255, max bus-wait cycles per access before abort with error; 0 disables timeout.

Ports:
CLK  in  1  clock
RST  in  1  reset
A_VALID  in  1  instruction in execute stage is valid
A_LOAD  in  1  instruction is a load
A_STORE  in  1  instruction is a store
A_FUNCT3  in  3  RV32I funct3 (size/sign)
A_ADDR  in  32  effective byte address
A_WDATA  in  32  store data (rs2, unshifted)
STALL  out  1  hold all upstream pipeline registers
M_LOAD_VALID  out  1  1-cycle pulse: M_LOAD_DATA valid
M_LOAD_DATA  out  32  extended load result
M_ERR  out  1  1-cycle pulse: access faulted
RD_ADDR  out  32  word-aligned read address
RD_VALID  out  1  read request valid
RD_READY  in  1  read request accepted
RD_DATA  in  32  read data word
RD_DVALID  in  1  RD_DATA valid
WR_ADDR  out  32  word-aligned write address
WR_DATA  out  32  lane-shifted write data
WR_STRB  out  4  byte enables
WR_VALID  out  1  write request valid
WR_READY  in  1  write accepted

Behaviour:
- Single clock CLK. Reset RST is synchronous and active-high.
- Reset: state IDLE, timeout counter 0. Every output is 0: STALL, M_LOAD_VALID, M_LOAD_DATA, M_ERR, RD_*/WR_* addresses, data, strobes and valids. Reset mid-transaction abandons the access; RD_VALID/WR_VALID are low the cycle after RST is sampled.
- FSM states:
  - IDLE
  - RD_REQ: RD_VALID=1
  - RD_WAIT: waiting for RD_DVALID
  - WR_REQ: WR_VALID=1
  - DONE: single cycle
- Accept: in IDLE with A_VALID=1 and exactly one of A_LOAD/A_STORE. Latch addr, funct3, wdata, op.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- Illegal funct3, misalignment, or A_LOAD&A_STORE both set: no bus access; go to DONE with M_ERR=1 there.
- Legal load: go to RD_REQ. Legal store: go to WR_REQ.
- STALL is combinational:
  - 1 in IDLE on an accept cycle;
  - 1 in RD_REQ, RD_WAIT and WR_REQ;
  - 0 in DONE and in IDLE with no accept.
- DONE always returns to IDLE and never accepts. A_* still shows the completed instruction in that cycle.
- RD_REQ: RD_ADDR = {addr[31:2],2'b00}, stable while RD_VALID=1. On RD_READY go to RD_WAIT. RD_DVALID is ignored in RD_REQ; the slave returns data no earlier than the cycle after the handshake.
- RD_WAIT: on RD_DVALID, capture the formatted data and go to DONE.
- Load formatting:
  - byte = RD_DATA[8*addr[1:0]+:8]; half = RD_DATA[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- WR_REQ: WR_ADDR word-aligned.
  - SB: WR_STRB = 1<<addr[1:0]; WR_DATA = byte replicated x4.
  - SH: WR_STRB = 0011 (addr[1]=0) or 1100; WR_DATA = half replicated x2.
  - SW: WR_STRB = 1111; WR_DATA = wdata.
  - On WR_READY go to DONE.
- DONE: for a successful load, M_LOAD_VALID=1 and M_LOAD_DATA = result. M_LOAD_DATA holds until the next load's DONE.
- Timeout: the counter increments each cycle in RD_REQ/RD_WAIT/WR_REQ and clears on entering IDLE. When it reaches TIMEOUT_CYC (nonzero):
  - drop VALID and go to DONE;
  - M_ERR=1, M_LOAD_VALID=0;
  - any late RD_DVALID is ignored in IDLE.
- Minimum latency with ready/dvalid always high: load accept T, RD handshake T+1, data T+2, DONE T+3 (3 stall cycles). Store accept T, WR handshake T+1, DONE T+2 (2 stall cycles).
- A_VALID=1 with neither A_LOAD nor A_STORE: no action, STALL=0.

Test Plan:
- LBU addr 0x1003, RD_DATA 0x80AABBCC, ready/dvalid immediate -> STALL high T..T+2; T+3 M_LOAD_VALID=1, M_LOAD_DATA=0x00000080, RD_ADDR=0x1000.
- LH addr 0x2002, RD_DATA 0x8001_1234, RD_READY delayed 4 cycles -> RD_VALID/RD_ADDR=0x2000 held stable 5 cycles; result 0xFFFF8001; no second read issued.
- SB addr 0x3001, A_WDATA 0x12345678 -> WR_STRB=0010, WR_DATA=0x78787878; DONE at T+2, M_LOAD_VALID=0.
- LW addr 0x4002 -> no RD_VALID, M_ERR pulse in DONE, STALL high one cycle only.
- TIMEOUT_CYC=8, SW with WR_READY stuck 0 -> WR_VALID drops after 8 cycles, M_ERR=1, FSM back to IDLE; the next load is accepted normally.
- RST asserted while in RD_WAIT -> next cycle all outputs 0, state IDLE; a subsequent RD_DVALID pulse produces no M_LOAD_VALID.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store sequencer driving a split read/write valid/ready bus
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_VALID,
  input  logic        A_LOAD,
  input  logic        A_STORE,
  input  logic [2:0]  A_FUNCT3,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_WDATA,
  output logic        STALL,
  output logic        M_LOAD_VALID,
  output logic [31:0] M_LOAD_DATA,
  output logic        M_ERR,
  output logic [31:0] RD_ADDR,
  output logic        RD_VALID,
  input  logic        RD_READY,
  input  logic [31:0] RD_DATA,
  input  logic        RD_DVALID,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_DATA,
  output logic [3:0]  WR_STRB,
  output logic        WR_VALID,
  input  logic        WR_READY
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] cnt_q;
  logic        accept, bad, to_hit;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ld_d, wdata_d;
  logic [3:0]  strb_d;
  // accept/legality decode, timeout detect, load extraction and store lane steering
  always_comb begin
    accept  = state_q == IDLE && A_VALID && (A_LOAD || A_STORE);
    bad     = (A_LOAD && A_STORE)
           || (A_LOAD ? !(A_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                      : !(A_FUNCT3 inside {3'b000, 3'b001, 3'b010}))
           || (A_FUNCT3[1:0] == 2'b01 && A_ADDR[0])
           || (A_FUNCT3[1:0] == 2'b10 && A_ADDR[1:0] != 2'b00);
    to_hit  = TIMEOUT_CYC != 0 && cnt_q == TIMEOUT_CYC - 1;
    STALL   = accept || state_q == RD_REQ || state_q == RD_WAIT || state_q == WR_REQ;
    b       = RD_DATA[{off_q, 3'b000} +: 8];
    h       = RD_DATA[{off_q[1], 4'b0000} +: 16];
    ld_d    = f3_q == 3'b000 ? {{24{b[7]}}, b}
            : f3_q == 3'b001 ? {{16{h[15]}}, h}
            : f3_q == 3'b100 ? {24'b0, b}
            : f3_q == 3'b101 ? {16'b0, h}
            : RD_DATA;
    strb_d  = A_FUNCT3[1:0] == 2'b00 ? 4'b0001 << A_ADDR[1:0]
            : A_FUNCT3[1:0] == 2'b01 ? (A_ADDR[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
    wdata_d = A_FUNCT3[1:0] == 2'b00 ? {4{A_WDATA[7:0]}}
            : A_FUNCT3[1:0] == 2'b01 ? {2{A_WDATA[15:0]}}
            : A_WDATA;
  end
  // access FSM with registered bus requests and one-cycle result/error pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      off_q        <= '0;
      f3_q         <= '0;
      cnt_q        <= '0;
      M_LOAD_VALID <= 1'b0;
      M_LOAD_DATA  <= '0;
      M_ERR        <= 1'b0;
      RD_ADDR      <= '0;
      RD_VALID     <= 1'b0;
      WR_ADDR      <= '0;
      WR_DATA      <= '0;
      WR_STRB      <= '0;
      WR_VALID     <= 1'b0;
    end else begin
      M_LOAD_VALID <= 1'b0;
      M_ERR        <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            off_q <= A_ADDR[1:0];
            f3_q  <= A_FUNCT3;
            if (bad) begin
              state_q <= DONE;
              M_ERR   <= 1'b1;
            end else if (A_LOAD) begin
              state_q  <= RD_REQ;
              RD_VALID <= 1'b1;
              RD_ADDR  <= {A_ADDR[31:2], 2'b00};
            end else begin
              state_q  <= WR_REQ;
              WR_VALID <= 1'b1;
              WR_ADDR  <= {A_ADDR[31:2], 2'b00};
              WR_STRB  <= strb_d;
              WR_DATA  <= wdata_d;
            end
          end
        end
        RD_REQ: begin
          cnt_q <= cnt_q + 1;
          if (to_hit) begin
            state_q  <= DONE;
            RD_VALID <= 1'b0;
            M_ERR    <= 1'b1;
          end else if (RD_READY) begin
            state_q  <= RD_WAIT;
            RD_VALID <= 1'b0;
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q + 1;
          if (RD_DVALID) begin
            state_q      <= DONE;
            M_LOAD_VALID <= 1'b1;
            M_LOAD_DATA  <= ld_d;
          end else if (to_hit) begin
            state_q <= DONE;
            M_ERR   <= 1'b1;
          end
        end
        WR_REQ: begin
          cnt_q <= cnt_q + 1;
          if (WR_READY) begin
            state_q  <= DONE;
            WR_VALID <= 1'b0;
          end else if (to_hit) begin
            state_q  <= DONE;
            WR_VALID <= 1'b0;
            M_ERR    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed-vector bench for mem_access_ctrl
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_load, a_store;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata;
  logic        stall, m_lv, m_err;
  logic [31:0] m_ld, rd_addr, rd_data, wr_addr, wr_data;
  logic        rd_valid, rd_ready, rd_dvalid, wr_valid, wr_ready;
  logic [3:0]  wr_strb;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.TIMEOUT_CYC(8)) dut (
    .CLK(clk), .RST(rst),
    .A_VALID(a_valid), .A_LOAD(a_load), .A_STORE(a_store), .A_FUNCT3(a_f3),
    .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .STALL(stall), .M_LOAD_VALID(m_lv), .M_LOAD_DATA(m_ld), .M_ERR(m_err),
    .RD_ADDR(rd_addr), .RD_VALID(rd_valid), .RD_READY(rd_ready),
    .RD_DATA(rd_data), .RD_DVALID(rd_dvalid),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_STRB(wr_strb),
    .WR_VALID(wr_valid), .WR_READY(wr_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, 32'(stall), 0);
    chk({tag, ".m_lv"}, 32'(m_lv), 0);
    chk({tag, ".m_ld"}, m_ld, 0);
    chk({tag, ".m_err"}, 32'(m_err), 0);
    chk({tag, ".rd_addr"}, rd_addr, 0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
    chk({tag, ".wr_strb"}, 32'(wr_strb), 0);
    chk({tag, ".wr_valid"}, 32'(wr_valid), 0);
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic set_a(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd);
    a_valid = v; a_load = ld; a_store = st; a_f3 = f3; a_addr = ad; a_wdata = wd;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; rd_ready = 0; rd_dvalid = 0; rd_data = 0; wr_ready = 0;
    set_a(0, 0, 0, 3'b000, 0, 0);
    cyc; cyc; #1 chk_zero("reset");
    // LBU 0x1003, immediate ready/dvalid
    cyc; rst = 1'b0; rd_ready = 1; rd_dvalid = 1; rd_data = 32'h80AABBCC;
    set_a(1, 1, 0, 3'b100, 32'h1003, 0);
    #1 chk("lbu.stall_t0", 32'(stall), 1);
    cyc; #1 chk("lbu.stall_t1", 32'(stall), 1); chk("lbu.rd_valid_t1", 32'(rd_valid), 1); chk("lbu.rd_addr", rd_addr, 32'h1000);
    cyc; #1 chk("lbu.stall_t2", 32'(stall), 1); chk("lbu.rd_valid_t2", 32'(rd_valid), 0);
    cyc; #1 chk("lbu.stall_t3", 32'(stall), 0); chk("lbu.m_lv", 32'(m_lv), 1); chk("lbu.m_ld", m_ld, 32'h00000080);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0);
    #1 chk("lbu.m_lv_t4", 32'(m_lv), 0); chk("lbu.m_ld_hold", m_ld, 32'h00000080); chk("lbu.stall_t4", 32'(stall), 0);
    // LH 0x2002, RD_READY delayed 4 cycles
    cyc; rd_ready = 0; rd_dvalid = 0; rd_data = 32'h80011234;
    set_a(1, 1, 0, 3'b001, 32'h2002, 0);
    #1 chk("lh.stall_t0", 32'(stall), 1);
    for (int i = 0; i < 4; i++) begin
      cyc; #1 chk("lh.rd_valid_wait", 32'(rd_valid), 1); chk("lh.rd_addr_wait", rd_addr, 32'h2000);
    end
    cyc; rd_ready = 1; #1 chk("lh.rd_valid_hs", 32'(rd_valid), 1); chk("lh.rd_addr_hs", rd_addr, 32'h2000);
    cyc; rd_ready = 0; rd_dvalid = 1; #1 chk("lh.rd_valid_wait2", 32'(rd_valid), 0); chk("lh.stall_wait", 32'(stall), 1);
    cyc; rd_dvalid = 0;
    #1 chk("lh.m_lv", 32'(m_lv), 1); chk("lh.m_ld", m_ld, 32'hFFFF8001); chk("lh.rd_valid_done", 32'(rd_valid), 0); chk("lh.stall_done", 32'(stall), 0);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0);
    #1 chk("lh.rd_valid_after", 32'(rd_valid), 0); chk("lh.m_lv_after", 32'(m_lv), 0);
    // SB 0x3001
    cyc; wr_ready = 1; set_a(1, 0, 1, 3'b000, 32'h3001, 32'h12345678);
    #1 chk("sb.stall_t0", 32'(stall), 1);
    cyc; #1 chk("sb.wr_valid", 32'(wr_valid), 1); chk("sb.wr_strb", 32'(wr_strb), 32'h2);
    chk("sb.wr_data", wr_data, 32'h78787878); chk("sb.wr_addr", wr_addr, 32'h3000); chk("sb.stall_t1", 32'(stall), 1);
    cyc; #1 chk("sb.stall_t2", 32'(stall), 0); chk("sb.wr_valid_t2", 32'(wr_valid), 0);
    chk("sb.m_lv", 32'(m_lv), 0); chk("sb.m_err", 32'(m_err), 0);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0);
    // SH 0x8002
    cyc; set_a(1, 0, 1, 3'b001, 32'h8002, 32'hAAAA5555);
    #1 chk("sh.stall_t0", 32'(stall), 1);
    cyc; #1 chk("sh.wr_strb", 32'(wr_strb), 32'hC); chk("sh.wr_data", wr_data, 32'h55555555); chk("sh.wr_addr", wr_addr, 32'h8000);
    cyc; #1 chk("sh.stall_t2", 32'(stall), 0);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0);
    // LW 0x4002 misaligned
    cyc; set_a(1, 1, 0, 3'b010, 32'h4002, 0);
    #1 chk("lwmis.stall_t0", 32'(stall), 1); chk("lwmis.rd_valid_t0", 32'(rd_valid), 0);
    cyc; #1 chk("lwmis.m_err", 32'(m_err), 1); chk("lwmis.stall_t1", 32'(stall), 0); chk("lwmis.rd_valid_t1", 32'(rd_valid), 0);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0); #1 chk("lwmis.m_err_t2", 32'(m_err), 0);
    // valid with neither load nor store
    cyc; set_a(1, 0, 0, 3'b010, 0, 0); #1 chk("none.stall", 32'(stall), 0);
    cyc; #1 chk("none.stall2", 32'(stall), 0); chk("none.m_err", 32'(m_err), 0);
    chk("none.rd_valid", 32'(rd_valid), 0); chk("none.wr_valid", 32'(wr_valid), 0);
    // load and store both set
    cyc; set_a(1, 1, 1, 3'b010, 0, 0); #1 chk("both.stall", 32'(stall), 1);
    cyc; #1 chk("both.m_err", 32'(m_err), 1); chk("both.rd_valid", 32'(rd_valid), 0); chk("both.wr_valid", 32'(wr_valid), 0);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0); #1 chk("both.m_err_t2", 32'(m_err), 0);
    // SW with WR_READY stuck low -> timeout after 8 cycles
    cyc; wr_ready = 0; set_a(1, 0, 1, 3'b010, 32'h5000, 32'hDEADBEEF);
    #1 chk("to.stall_t0", 32'(stall), 1);
    for (int i = 0; i < 8; i++) begin
      cyc; #1 chk("to.wr_valid", 32'(wr_valid), 1); chk("to.stall", 32'(stall), 1);
    end
    chk("to.wr_data", wr_data, 32'hDEADBEEF); chk("to.wr_strb", 32'(wr_strb), 32'hF);
    cyc; #1 chk("to.wr_valid_drop", 32'(wr_valid), 0); chk("to.m_err", 32'(m_err), 1);
    chk("to.m_lv", 32'(m_lv), 0); chk("to.stall_done", 32'(stall), 0);
    cyc; rd_ready = 1; rd_dvalid = 1; rd_data = 32'hCAFEF00D;
    set_a(1, 1, 0, 3'b010, 32'h6000, 0);
    #1 chk("to.next_stall", 32'(stall), 1); chk("to.next_m_err", 32'(m_err), 0);
    cyc; #1 chk("to.next_rd_valid", 32'(rd_valid), 1); chk("to.next_rd_addr", rd_addr, 32'h6000);
    cyc; #1 chk("to.next_rd_valid2", 32'(rd_valid), 0);
    cyc; #1 chk("to.next_m_lv", 32'(m_lv), 1); chk("to.next_m_ld", m_ld, 32'hCAFEF00D);
    cyc; set_a(0, 0, 0, 3'b000, 0, 0);
    // reset while in RD_WAIT
    cyc; rd_ready = 1; rd_dvalid = 0; set_a(1, 1, 0, 3'b100, 32'h7000, 0);
    #1 chk("rst.stall_t0", 32'(stall), 1);
    cyc; #1 chk("rst.rd_valid_t1", 32'(rd_valid), 1);
    cyc; #1 chk("rst.rd_valid_t2", 32'(rd_valid), 0); chk("rst.stall_t2", 32'(stall), 1);
    rst = 1'b1; set_a(0, 0, 0, 3'b000, 0, 0);
    cyc; rst = 1'b0; rd_dvalid = 1; #1 chk_zero("rst_mid");
    cyc; rd_dvalid = 0; #1 chk("rst.m_lv_late", 32'(m_lv), 0); chk("rst.stall_late", 32'(stall), 0);
    cyc; #1 chk("rst.m_lv_late2", 32'(m_lv), 0); chk("rst.m_ld_late2", m_ld, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
